// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with glitch-free half-period reload.
// Optional CLKDIV_SYNC_EN adds an isync input that phase-aligns all enabled channels.
module clkdiv_multi #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int DEFAULT_HALF = 25000000,
    parameter int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              iload,
    input  logic [SEL_W-1:0]  isel,
    input  logic [CNT_W-1:0]  ihalf,
    input  logic [NUM_CH-1:0] ien,
`ifdef CLKDIV_SYNC_EN
    input  logic              isync,
`endif
    output logic [NUM_CH-1:0] oclk,
    output logic [NUM_CH-1:0] otick,
    output logic [NUM_CH-1:0] opending
);

    localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEFAULT_HALF);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  h_q   [NUM_CH];
    logic [CNT_W-1:0]  h_d   [NUM_CH];
    logic [CNT_W-1:0]  p_q   [NUM_CH];
    logic [CNT_W-1:0]  p_d   [NUM_CH];
    logic [NUM_CH-1:0] oclk_q, oclk_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] hit;
    logic [CNT_W-1:0]  half_in;
    logic              sync_req;

`ifdef CLKDIV_SYNC_EN
    assign sync_req = isync;
`else
    assign sync_req = 1'b0;
`endif

    // Zero is not a usable half-period; it is stored as 1.
    assign half_in = (ihalf == '0) ? ONE : ihalf;

    // isel values beyond the last channel match no index and are ignored.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = iload && (isel == SEL_W'(i));
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        h_d    = h_q;
        p_d    = p_q;
        oclk_d = oclk_q;
        tick_d = '0;
        pend_d = pend_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit[i]) begin
                p_d[i] = half_in;
            end
            if (!ien[i] || sync_req) begin
                // Disable and sync both restart the phase and flush any pending value.
                cnt_d[i]  = '0;
                oclk_d[i] = 1'b0;
                if (pend_q[i]) begin
                    h_d[i] = p_q[i];
                end
                pend_d[i] = hit[i];
            end else if (cnt_q[i] >= h_q[i] - ONE) begin
                cnt_d[i]  = '0;
                oclk_d[i] = ~oclk_q[i];
                tick_d[i] = ~oclk_q[i];
                if (oclk_q[i]) begin
                    if (hit[i]) begin
                        h_d[i]    = half_in;
                        pend_d[i] = 1'b0;
                    end else if (pend_q[i]) begin
                        h_d[i]    = p_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else if (hit[i]) begin
                    pend_d[i] = 1'b1;
                end
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
                if (hit[i]) begin
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                h_q[i]   <= DEF_H;
                p_q[i]   <= DEF_H;
            end
            oclk_q <= '0;
            tick_q <= '0;
            pend_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            h_q    <= h_d;
            p_q    <= p_d;
            oclk_q <= oclk_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign oclk     = oclk_q;
    assign otick    = tick_q;
    assign opending = pend_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: vector table plus hand-written reset, invalid-select and sync sequences.
module tb_clkdiv_multi;

    typedef struct {
        logic [3:0]  ien;
        logic        ld;
        logic [1:0]  sel;
        logic [31:0] half;
        logic [3:0]  exp_oclk;
        logic [3:0]  exp_tick;
        logic [3:0]  exp_pend;
    } vec_t;

    logic        iclk;
    logic        irst_n;
    logic        iload;
    logic [1:0]  isel;
    logic [31:0] ihalf;
    logic [3:0]  ien;
    logic [3:0]  oclk, otick, opending;
`ifdef CLKDIV_SYNC_EN
    logic        isync;
    logic        isync3;
`endif

    logic        iload3;
    logic [1:0]  isel3;
    logic [31:0] ihalf3;
    logic [2:0]  ien3;
    logic [2:0]  oclk3, otick3, opending3;

    int nvec = 0;
    int nerr = 0;
    vec_t vecs[41];

    clkdiv_multi #(.NUM_CH(4), .CNT_W(32), .DEFAULT_HALF(3)) u_dut (
        .iclk     (iclk),
        .irst_n   (irst_n),
        .iload    (iload),
        .isel     (isel),
        .ihalf    (ihalf),
        .ien      (ien),
`ifdef CLKDIV_SYNC_EN
        .isync    (isync),
`endif
        .oclk     (oclk),
        .otick    (otick),
        .opending (opending)
    );

    // Three channels leave isel=3 as an out-of-range select.
    clkdiv_multi #(.NUM_CH(3), .CNT_W(32), .DEFAULT_HALF(2)) u_dut3 (
        .iclk     (iclk),
        .irst_n   (irst_n),
        .iload    (iload3),
        .isel     (isel3),
        .ihalf    (ihalf3),
        .ien      (ien3),
`ifdef CLKDIV_SYNC_EN
        .isync    (isync3),
`endif
        .oclk     (oclk3),
        .otick    (otick3),
        .opending (opending3)
    );

    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    function automatic vec_t mk(logic [3:0] e, logic l, logic [1:0] s, logic [31:0] h,
                                logic [3:0] oc, logic [3:0] ot, logic [3:0] op);
        vec_t v;
        v.ien = e; v.ld = l; v.sel = s; v.half = h;
        v.exp_oclk = oc; v.exp_tick = ot; v.exp_pend = op;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    initial begin
        // Edge k after reset release; H=3 on all channels until loads take effect.
        vecs[0]  = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[1]  = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[2]  = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000);
        vecs[3]  = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b0000, 4'b0000);
        vecs[4]  = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b0000, 4'b0000);
        vecs[5]  = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[6]  = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[7]  = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[8]  = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000);
        vecs[9]  = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b0000, 4'b0000);
        vecs[10] = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b0000, 4'b0000);
        vecs[11] = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[12] = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[13] = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[14] = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000);
        vecs[15] = mk(4'b1111, 1, 1, 1, 4'b1111, 4'b0000, 4'b0010);
        vecs[16] = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b0000, 4'b0010);
        vecs[17] = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[18] = mk(4'b1111, 0, 0, 0, 4'b0010, 4'b0010, 4'b0000);
        vecs[19] = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[20] = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000);
        vecs[21] = mk(4'b1111, 0, 0, 0, 4'b1101, 4'b0000, 4'b0000);
        vecs[22] = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b0010, 4'b0000);
        vecs[23] = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[24] = mk(4'b1111, 1, 2, 0, 4'b0010, 4'b0010, 4'b0100);
        vecs[25] = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0100);
        vecs[26] = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b1111, 4'b0100);
        vecs[27] = mk(4'b1111, 0, 0, 0, 4'b1101, 4'b0000, 4'b0100);
        vecs[28] = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b0010, 4'b0100);
        vecs[29] = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[30] = mk(4'b1111, 0, 0, 0, 4'b0110, 4'b0110, 4'b0000);
        vecs[31] = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[32] = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000);
        vecs[33] = mk(4'b1111, 0, 0, 0, 4'b1001, 4'b0000, 4'b0000);
        vecs[34] = mk(4'b0111, 0, 0, 0, 4'b0111, 4'b0110, 4'b0000);
        vecs[35] = mk(4'b0111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[36] = mk(4'b1111, 0, 0, 0, 4'b0110, 4'b0110, 4'b0000);
        vecs[37] = mk(4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        vecs[38] = mk(4'b1111, 0, 0, 0, 4'b1111, 4'b1111, 4'b0000);
        vecs[39] = mk(4'b1111, 0, 0, 0, 4'b1001, 4'b0000, 4'b0000);
        vecs[40] = mk(4'b1011, 1, 0, 5, 4'b1011, 4'b0010, 4'b0001);

        irst_n = 1'b0;
        iload = 1'b0; isel = '0; ihalf = '0; ien = 4'b1111;
        iload3 = 1'b0; isel3 = '0; ihalf3 = '0; ien3 = 3'b111;
`ifdef CLKDIV_SYNC_EN
        isync = 1'b0;
        isync3 = 1'b0;
`endif
        #2;
        chk("reset oclk", oclk, 4'b0000);
        chk("reset otick", otick, 4'b0000);
        chk("reset opending", opending, 4'b0000);
        @(posedge iclk);
        #3 irst_n = 1'b1;

        for (int i = 0; i < 41; i++) begin
            ien   = vecs[i].ien;
            iload = vecs[i].ld;
            isel  = vecs[i].sel;
            ihalf = vecs[i].half;
            step();
            chk($sformatf("v%0d oclk", i + 1), oclk, vecs[i].exp_oclk);
            chk($sformatf("v%0d otick", i + 1), otick, vecs[i].exp_tick);
            chk($sformatf("v%0d opending", i + 1), opending, vecs[i].exp_pend);
        end
        iload = 1'b0;

        // Async reset between edges with oclk active and a load pending on channel 0.
        #2 irst_n = 1'b0;
        #1;
        chk("async rst oclk", oclk, 4'b0000);
        chk("async rst otick", otick, 4'b0000);
        chk("async rst opending", opending, 4'b0000);
        step();
        chk("held rst oclk", oclk, 4'b0000);
        ien = 4'b1111;
        ien3 = 3'b111;
        #2 irst_n = 1'b1;

        // Channel 0 must be back on H=3, not the discarded 5; dut3 load with isel=3 is ignored.
        for (int k = 1; k <= 6; k++) begin
            iload3 = (k == 1);
            isel3  = 2'd3;
            ihalf3 = 32'd1;
            step();
            chk($sformatf("post rst k%0d oclk", k), oclk, (k >= 3 && k < 6) ? 4'b1111 : 4'b0000);
            chk($sformatf("post rst k%0d otick", k), otick, (k == 3) ? 4'b1111 : 4'b0000);
            chk($sformatf("post rst k%0d opending", k), opending, 4'b0000);
            chk($sformatf("bad sel k%0d oclk3", k), {1'b0, oclk3},
                (k == 2 || k == 3 || k == 6) ? 4'b0111 : 4'b0000);
            chk($sformatf("bad sel k%0d opending3", k), {1'b0, opending3}, 4'b0000);
        end
        iload3 = 1'b0;

`ifdef CLKDIV_SYNC_EN
        // Put channel 1 on H=5 while disabled, stagger the enables, then align with isync.
        ien = 4'b0000;
        iload = 1'b1; isel = 2'd1; ihalf = 32'd5;
        step();
        iload = 1'b0;
        step();
        chk("sync setup opending", opending, 4'b0000);
        ien = 4'b0001;
        step();
        step();
        ien = 4'b0011;
        step();
        step();
        step();
        isync = 1'b1;
        step();
        isync = 1'b0;
        chk("sync oclk", oclk, 4'b0000);
        chk("sync otick", otick, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("sync k%0d oclk", k), oclk,
                {2'b00, (k >= 5) ? 1'b1 : 1'b0, (k >= 3) ? 1'b1 : 1'b0});
            chk($sformatf("sync k%0d otick", k), otick,
                {2'b00, (k == 5) ? 1'b1 : 1'b0, (k == 3) ? 1'b1 : 1'b0});
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
